// File: rtl/sysgen_capture_pkg.sv
// sysgen_capture_pkg
// Shared types and constants for the System Generator result capture block:
// FIFO word layout, field positions, capture state encoding and a word-packing
// helper used by the top level.
package sysgen_capture_pkg;

  localparam int WORD_W   = 32;
  localparam int SAMPLE_W = 25;
  localparam int LAST_BIT = 25;
  localparam int IDX_LSB  = 26;
  localparam int IDX_W    = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNC    = 2'd1,
    CAPTURE = 2'd2
  } cap_state_t;

  // Builds one FIFO word: sample in the low bits, last marker, frame index on top.
  function automatic logic [WORD_W-1:0] pack_word(input logic [SAMPLE_W-1:0] sample,
                                                   input logic                last,
                                                   input logic [IDX_W-1:0]    idx);
    logic [WORD_W-1:0] w;
    w                    = '0;
    w[SAMPLE_W-1:0]      = sample;
    w[LAST_BIT]          = last;
    w[IDX_LSB +: IDX_W]  = idx;
    return w;
  endfunction

endpackage

// File: rtl/sysgen_capture_if.sv
// sysgen_capture_if
// Bundles the SysGen sample stream and the downstream read port.
//   data_out  [24:0] : sample from SysGen
//   data_out1        : sample valid strobe
//   data_out2        : frame-last marker (qualified by data_out1)
//   rd_en            : pop request from the reader
//   rd_data   [31:0] : FIFO head word (show-ahead)
//   rd_valid         : FIFO non-empty
// Modports: master = SysGen source plus reader, slave = capture block.
interface sysgen_capture_if;
  import sysgen_capture_pkg::*;

  logic [SAMPLE_W-1:0] data_out;
  logic                data_out1;
  logic                data_out2;
  logic                rd_en;
  logic [WORD_W-1:0]   rd_data;
  logic                rd_valid;

  modport master (output data_out, data_out1, data_out2, rd_en,
                  input  rd_data, rd_valid);

  modport slave  (input  data_out, data_out1, data_out2, rd_en,
                  output rd_data, rd_valid);
endinterface

// File: rtl/sysgen_capture_fifo.sv
// sysgen_capture_fifo
// Synchronous show-ahead FIFO. The head word is visible on o_rdata whenever
// the FIFO is non-empty and reads as zero when empty.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   i_flush          : empties the FIFO, overrides write and read
//   i_wr, i_wdata    : write request and word
//   i_rd             : pop request (ignored when empty)
//   o_rdata          : head word
//   o_empty, o_full  : status
//   o_level          : occupancy, 0..DEPTH
module sysgen_capture_fifo
  import sysgen_capture_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_flush,
  input  logic                     i_wr,
  input  logic [WORD_W-1:0]        i_wdata,
  input  logic                     i_rd,
  output logic [WORD_W-1:0]        o_rdata,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wptr;
  logic [AW:0]       r_rptr;
  logic [AW:0]       r_level;
  logic              w_rd;
  logic              w_wr;

  // Pointers carry one extra MSB: equal pointers mean empty, equal index with
  // differing MSB means full.
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

  // A write while full is legal only when the head leaves in the same cycle.
  assign w_rd = i_rd & ~o_empty & ~i_flush;
  assign w_wr = i_wr & (~o_full | w_rd) & ~i_flush;

  assign o_rdata = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];
  assign o_level = r_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + PTR_ONE;
      if (w_rd) r_rptr <= r_rptr + PTR_ONE;
      if (w_wr && !w_rd)      r_level <= r_level + PTR_ONE;
      else if (!w_wr && w_rd) r_level <= r_level - PTR_ONE;
    end
  end

  // Storage carries no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/sysgen_capture.sv
// sysgen_capture
// Result-side receiver for the System Generator datapath. Aligns the sample
// stream to frame boundaries and buffers whole frames into a show-ahead FIFO.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   enable       : capture enable (level)
//   clear        : synchronous flush pulse, highest priority
//   cap          : sysgen_capture_if.slave (sample stream + read port)
//   level        : FIFO occupancy
//   almost_full  : level >= AFULL_LVL
//   overflow     : sticky, a sample was dropped on a full FIFO
//   frame_done   : one-cycle pulse after a last sample is stored
// Build option: define SYSGEN_CAPTURE_FRAME_IDX_EN to place a 6-bit frame
// index in word bits [31:26]; otherwise those bits are 0.
module sysgen_capture
  import sysgen_capture_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int AFULL_LVL = DEPTH - 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   clear,
  sysgen_capture_if.slave        cap,
  output logic [$clog2(DEPTH):0] level,
  output logic                   almost_full,
  output logic                   overflow,
  output logic                   frame_done
);

  localparam int LW = $clog2(DEPTH) + 1;

  cap_state_t         r_state;
  logic               r_overflow;
  logic               r_frame_done;
  logic               r_afull;
  logic               w_empty;
  logic               w_full;
  logic               w_pop;
  logic               w_wr;
  logic               w_drop;
  logic               w_last_wr;
  logic [IDX_W-1:0]   w_idx;
  logic [WORD_W-1:0]  w_wdata;
  logic [LW-1:0]      w_level;
  logic [LW-1:0]      w_level_nxt;

  assign w_pop     = cap.rd_en & ~w_empty & ~clear;
  assign w_wr      = ~clear & (r_state == CAPTURE) & cap.data_out1 & (~w_full | w_pop);
  assign w_drop    = ~clear & (r_state == CAPTURE) & cap.data_out1 & w_full & ~w_pop;
  assign w_last_wr = w_wr & cap.data_out2;

`ifdef SYSGEN_CAPTURE_FRAME_IDX_EN
  logic [IDX_W-1:0] r_idx;

  // Index of the frame currently being stored; advances past each stored last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_idx <= '0;
    else if (clear)     r_idx <= '0;
    else if (w_last_wr) r_idx <= r_idx + IDX_W'(1);
  end

  assign w_idx = r_idx;
`else
  assign w_idx = '0;
`endif

  assign w_wdata = pack_word(cap.data_out, cap.data_out2, w_idx);

  sysgen_capture_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (clear),
    .i_wr    (w_wr),
    .i_wdata (w_wdata),
    .i_rd    (w_pop),
    .o_rdata (cap.rd_data),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_level (w_level)
  );

  // Occupancy after this edge, so almost_full updates together with level.
  always_comb begin
    w_level_nxt = w_level;
    if (clear)              w_level_nxt = '0;
    else if (w_wr && !w_pop) w_level_nxt = w_level + LW'(1);
    else if (!w_wr && w_pop) w_level_nxt = w_level - LW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_overflow   <= 1'b0;
      r_frame_done <= 1'b0;
      r_afull      <= 1'b0;
    end else begin
      r_frame_done <= w_last_wr;
      r_afull      <= (w_level_nxt >= LW'(AFULL_LVL));
      if (clear) begin
        r_overflow <= 1'b0;
        r_state    <= enable ? SYNC : IDLE;
      end else begin
        if (w_drop) r_overflow <= 1'b1;
        case (r_state)
          IDLE:    if (enable) r_state <= SYNC;
          // The last sample that ends the hunt is itself discarded.
          SYNC:    if (!enable)                           r_state <= IDLE;
                   else if (cap.data_out1 && cap.data_out2) r_state <= CAPTURE;
          // After a drop the remainder of the frame must be skipped.
          CAPTURE: if (!enable)    r_state <= IDLE;
                   else if (w_drop) r_state <= SYNC;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign level        = w_level;
  assign almost_full  = r_afull;
  assign overflow     = r_overflow;
  assign frame_done   = r_frame_done;
  assign cap.rd_valid = ~w_empty;

endmodule

// File: tb/tb_sysgen_capture.sv
module tb_sysgen_capture;

  localparam int DEPTH = 16;
  localparam int AFULL = DEPTH - 2;
  localparam int LW    = $clog2(DEPTH) + 1;

  localparam int M_OFF  = 0;  // not capturing, waiting for enable
  localparam int M_HUNT = 1;  // looking for a frame boundary
  localparam int M_CAPT = 2;  // storing samples

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          clear = 1'b0;
  logic [LW-1:0] level;
  logic          almost_full;
  logic          overflow;
  logic          frame_done;

  sysgen_capture_if cif();

  sysgen_capture #(.DEPTH(DEPTH), .AFULL_LVL(AFULL)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .clear       (clear),
    .cap         (cif),
    .level       (level),
    .almost_full (almost_full),
    .overflow    (overflow),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] mq[$];
  bit          m_ovf;
  bit          m_fd;
  int          m_idx;
  int          m_mode;

  int n_checks = 0;
  int n_fails  = 0;
  int fd_seen  = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_word(input logic [24:0] s, input logic last, input int idx);
    logic [31:0] w;
    w = {7'd0, s};
    w[25] = last;
`ifdef SYSGEN_CAPTURE_FRAME_IDX_EN
    w[31:26] = 6'(idx);
`endif
    return w;
  endfunction

  function automatic int exp_idx(input int k);
`ifdef SYSGEN_CAPTURE_FRAME_IDX_EN
    return k % 64;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ovf  = 0;
    m_fd   = 0;
    m_idx  = 0;
    m_mode = M_OFF;
  endtask

  // One clock edge of behaviour, from the inputs present at that edge.
  task automatic model_step();
    int sz;
    bit pop;
    bit drop;
    sz   = mq.size();
    pop  = cif.rd_en && (sz > 0);
    drop = 0;
    if (clear) begin
      mq.delete();
      m_ovf  = 0;
      m_idx  = 0;
      m_fd   = 0;
      m_mode = enable ? M_HUNT : M_OFF;
      return;
    end
    m_fd = 0;
    if (pop) void'(mq.pop_front());
    if (m_mode == M_CAPT && cif.data_out1) begin
      if (sz < DEPTH || pop) begin
        mq.push_back(mk_word(cif.data_out, cif.data_out2, m_idx));
        if (cif.data_out2) begin
          m_fd  = 1;
          m_idx = (m_idx + 1) % 64;
        end
      end else begin
        m_ovf = 1;
        drop  = 1;
      end
    end
    if (m_mode == M_OFF) begin
      if (enable) m_mode = M_HUNT;
    end else if (!enable) begin
      m_mode = M_OFF;
    end else if (m_mode == M_HUNT) begin
      if (cif.data_out1 && cif.data_out2) m_mode = M_CAPT;
    end else if (drop) begin
      m_mode = M_HUNT;
    end
  endtask

  task automatic check_all();
    int sz;
    sz = mq.size();
    chk_eq("level",       32'(level),        32'(sz));
    chk_eq("rd_valid",    32'(cif.rd_valid), 32'(sz > 0));
    chk_eq("rd_data",     cif.rd_data,       (sz > 0) ? mq[0] : 32'd0);
    chk_eq("almost_full", 32'(almost_full),  32'(sz >= AFULL));
    chk_eq("overflow",    32'(overflow),     32'(m_ovf));
    chk_eq("frame_done",  32'(frame_done),   32'(m_fd));
  endtask

  task automatic set_in(input logic v, input logic l, input logic [24:0] d, input logic r);
    cif.data_out1 = v;
    cif.data_out2 = l;
    cif.data_out  = d;
    cif.rd_en     = r;
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step();
    #1;
    if (frame_done) fd_seen++;
    check_all();
  endtask

  // Sends n valid samples starting at base; last marker on the final one.
  task automatic send_frame(input int n, input logic [24:0] base, input logic pop);
    for (int i = 0; i < n; i++) begin
      set_in(1'b1, (i == n - 1), base + 25'(i), pop);
      step();
    end
    set_in(1'b0, 1'b0, 25'd0, 1'b0);
  endtask

  initial begin
    set_in(1'b0, 1'b0, 25'd0, 1'b0);
    model_reset();

    // Reset state
    step();
    step();
    rst_n = 1'b1;
    step();

    // Dummy frame then a 4-sample frame
    enable = 1'b1;
    step();
    send_frame(3, 25'h0000AA, 1'b0);
    fd_seen = 0;
    send_frame(4, 25'h1000001, 1'b0);
    step();
    chk_eq("first_frame_level", 32'(level), 32'd4);
    chk_eq("first_frame_fd_count", 32'(fd_seen), 32'd1);
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 1'b0, 25'd0, 1'b1);
      step();
    end
    chk_eq("first_frame_last_word", cif.rd_data, {6'd0, 1'b1, 25'h1000004});
    set_in(1'b0, 1'b0, 25'd0, 1'b1);
    step();

    // Overflow on a 20-sample frame, then resync and an 8-sample frame with pops
    send_frame(20, 25'h0100000, 1'b0);
    chk_eq("ovf_level", 32'(level), 32'd16);
    chk_eq("ovf_flag",  32'(overflow), 32'd1);
    send_frame(8, 25'h0200000, 1'b1);
    chk_eq("full_pop_level", 32'(level), 32'd16);
    chk_eq("full_pop_ovf",   32'(overflow), 32'd1);
    for (int i = 0; i < 16; i++) begin
      set_in(1'b0, 1'b0, 25'd0, 1'b1);
      step();
    end

    // Clear with level 7, overflow set and a sample arriving
    send_frame(7, 25'h0300000, 1'b0);
    chk_eq("pre_clear_level", 32'(level), 32'd7);
    set_in(1'b1, 1'b0, 25'h0300100, 1'b1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk_eq("clear_level",    32'(level), 32'd0);
    chk_eq("clear_ovf",      32'(overflow), 32'd0);
    chk_eq("clear_rd_valid", 32'(cif.rd_valid), 32'd0);
    set_in(1'b1, 1'b0, 25'h0300200, 1'b0);
    step();
    set_in(1'b1, 1'b1, 25'h0300201, 1'b0);
    step();
    set_in(1'b1, 1'b0, 25'h0300202, 1'b0);
    step();
    chk_eq("post_clear_sync_level", 32'(level), 32'd1);

    // 65 single-sample frames with continuous pops
    set_in(1'b0, 1'b0, 25'd0, 1'b0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    set_in(1'b1, 1'b1, 25'h0000001, 1'b0);
    step();
    for (int k = 0; k < 65; k++) begin
      set_in(1'b1, 1'b1, 25'h0400000 + 25'(k), 1'b1);
      step();
      chk_eq("frame_idx", 32'(cif.rd_data[31:26]), 32'(exp_idx(k)));
    end
    set_in(1'b0, 1'b0, 25'd0, 1'b1);
    step();

    // Reset mid-frame with level 5
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 1'b0, 25'h0500000 + 25'(i), 1'b0);
      step();
    end
    set_in(1'b0, 1'b0, 25'd0, 1'b0);
    chk_eq("pre_reset_level", 32'(level), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 1'b0, 25'h0600000 + 25'(i), 1'b0);
      step();
    end
    chk_eq("post_reset_no_capture", 32'(level), 32'd0);
    send_frame(2, 25'h0600100, 1'b0);
    send_frame(3, 25'h0600200, 1'b0);

    // Randomized traffic
    for (int c = 0; c < 800; c++) begin
      enable = ($urandom_range(0, 99) < 95);
      clear  = ($urandom_range(0, 99) < 2);
      set_in(($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 20),
             25'($urandom), ($urandom_range(0, 99) < 45));
      step();
    end
    clear = 1'b0;
    set_in(1'b0, 1'b0, 25'd0, 1'b0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
